rot_loader: RTL and testbench

ROT_LOADER -- requirements
Module: rot_loader

---
 rtl/rot_loader.sv | 122 ++++++++++++
 tb/tb_rot_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_loader.sv
// rot_loader: assembles an N-bit vector and its rotate amount from W-bit
// beats, then offers the result to the log2-stage rotator over a
// valid/ready handshake. There is no bypass: a vector is emitted once fully
// assembled, and the loader only refills after the vector has been taken.
module rot_loader #(
    parameter int N      = 128,  // vector width, power of two
    parameter int log2_N = 7,    // rotate-amount width, log2(N)
    parameter int W      = 32    // beat width, N/W >= 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:W-1]      in_data,
    input  logic [log2_N-1:0] in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:N-1]      out_bits,
    output logic [0:log2_N-1] out_k
);

    localparam int BEATS = N / W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_cnt;
    logic [0:N-1]        r_bits;
    logic [0:log2_N-1]   r_k;
    logic                w_accept;
    logic                w_last;

    // A beat is taken only while filling; in FULL the upstream is ignored.
    assign w_accept = in_valid && (r_state == FILL);
    assign w_last   = (r_cnt == LAST_BEAT);

    // Handshake flags decode the state register only, so neither has a
    // combinational path from in_valid or out_ready.
    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == FULL);
    assign out_bits  = r_bits;
    assign out_k     = r_k;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: fill until the last beat, then hold until drained.
    always_comb begin
        // NOTE: defaulting the next state first keeps every path assigned,
        // so no latch is inferred when a branch leaves the state alone.
        w_state_next = r_state;
        case (r_state)
            FILL: begin
                if (w_accept && w_last) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    w_state_next = FILL;
                end
            end
            default: begin
                w_state_next = FILL;
            end
        endcase
    end

    // Beat counter: advances per accepted beat and wraps only on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Vector assembly: beat j lands in out_bits[j*W : j*W+W-1], in_data[0] first.
    always_ff @(posedge clk) begin
        // NOTE: the data register is reset because downstream observes an
        // all-zero vector after reset, and a pending vector must be discarded.
        if (rst) begin
            r_bits <= '0;
        end else if (w_accept) begin
            for (int b = 0; b < BEATS; b++) begin
                if (r_cnt == CW'(b)) begin
                    r_bits[b*W +: W] <= in_data;
                end
            end
        end
    end

    // Rotate amount: captured on beat 0 only; out_k[0] is the amount's LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k <= '0;
        end else if (w_accept && (r_cnt == '0)) begin
            for (int i = 0; i < log2_N; i++) begin
                r_k[i] <= in_k[i];
            end
        end
    end

endmodule

// File: tb/tb_rot_loader.sv
// tb_rot_loader: directed bench for rot_loader (N=128, W=32). Each task drives
// one scenario and compares outputs 1 time unit after the rising edge against
// hand-built expected vectors.
`timescale 1ns/1ps
module tb_rot_loader;

    localparam int N  = 128;
    localparam int LN = 7;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [0:W-1]    in_data;
    logic [LN-1:0]   in_k;
    logic            out_valid;
    logic            out_ready;
    logic [0:N-1]    out_bits;
    logic [0:LN-1]   out_k;

    int n_checks = 0;
    int n_fail   = 0;

    rot_loader #(.N(N), .log2_N(LN), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_k     (in_k),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits (out_bits),
        .out_k    (out_k)
    );

    always #5 clk = ~clk;

    // Expected out_k: bit i of the amount appears on out_k[i].
    function automatic logic [0:LN-1] map_k(input logic [LN-1:0] k);
        logic [0:LN-1] r;
        for (int i = 0; i < LN; i++) r[i] = k[i];
        return r;
    endfunction

    // Expected vector: beat 0 occupies out_bits[0:31], its index 0 first.
    function automatic logic [0:N-1] pack4(input logic [0:W-1] a, input logic [0:W-1] b,
                                           input logic [0:W-1] c, input logic [0:W-1] d);
        return {a, b, c, d};
    endfunction

    function automatic logic [0:W-1] stream_beat(input int v, input int p);
        return 32'hC0DE0000 | 32'(v << 8) | 32'(p);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back 4-beat load; k is presented on every beat, only beat 0 counts.
    task automatic load4(input logic [0:W-1] a, input logic [0:W-1] b,
                         input logic [0:W-1] c, input logic [0:W-1] d,
                         input logic [LN-1:0] k);
        in_valid = 1'b1;
        in_data = a; in_k = k;          tick();
        in_data = b; in_k = ~k;         tick();
        in_data = c; in_k = k ^ 7'h2a;  tick();
        in_data = d; in_k = 7'h7f;      tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h12345678; in_k = 7'd9; out_ready = 1'b0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_bits !== '0) begin n_fail++; $display("FAIL reset_out_bits got %h exp 0", out_bits); end
        n_checks++; if (out_k !== '0) begin n_fail++; $display("FAIL reset_out_k got %b exp 0", out_k); end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic_load();
        logic [0:W-1] beats [4];
        logic [0:N-1] exp_bits;
        beats[0] = 32'h80000000; beats[1] = '0; beats[2] = '0; beats[3] = '0;
        exp_bits = pack4(beats[0], beats[1], beats[2], beats[3]);
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid beat %0d got %b exp 0", j, out_valid); end
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready beat %0d got %b exp 1", j, in_ready); end
            in_valid = 1'b1; in_data = beats[j];
            in_k = (j == 0) ? 7'd3 : 7'h55;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid got %b exp 1", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_full_in_ready got %b exp 0", in_ready); end
        n_checks++; if (out_bits !== exp_bits) begin n_fail++; $display("FAIL basic_out_bits got %h exp %h", out_bits, exp_bits); end
        n_checks++; if (out_bits[0] !== 1'b1) begin n_fail++; $display("FAIL basic_bit0 got %b exp 1", out_bits[0]); end
        n_checks++; if (out_k !== map_k(7'd3)) begin n_fail++; $display("FAIL basic_out_k got %b exp %b", out_k, map_k(7'd3)); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain_valid got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_drain_ready got %b exp 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [0:N-1] exp_bits;
        exp_bits = pack4(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
        out_ready = 1'b0;
        load4(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210, 7'd5);
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d got %b exp 1", c, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b exp 0", c, in_ready); end
            n_checks++; if (out_bits !== exp_bits) begin n_fail++; $display("FAIL bp_bits cycle %0d got %h exp %h", c, out_bits, exp_bits); end
            n_checks++; if (out_k !== map_k(7'd5)) begin n_fail++; $display("FAIL bp_k cycle %0d got %b exp %b", c, out_k, map_k(7'd5)); end
            in_valid = 1'b1; in_data = 32'hDEADBEEF; in_k = 7'h7f;
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_bits !== exp_bits) begin n_fail++; $display("FAIL bp_bits_final got %h exp %h", out_bits, exp_bits); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_gappy();
        logic [0:W-1] beats [4];
        logic         vpat  [7];
        logic [0:N-1] exp_bits;
        int           b;
        beats[0] = 32'hAAAA0001; beats[1] = 32'hBBBB0002;
        beats[2] = 32'hCCCC0003; beats[3] = 32'hDDDD0004;
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_bits = pack4(beats[0], beats[1], beats[2], beats[3]);
        out_ready = 1'b0;
        b = 0;
        for (int c = 0; c < 7; c++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid cycle %0d got %b exp 0", c, out_valid); end
            in_valid = vpat[c];
            if (vpat[c]) begin
                in_data = beats[b];
                in_k = (b == 0) ? 7'd9 : 7'h22;
                b++;
            end else begin
                in_data = 32'h0BAD0BAD;
                in_k = 7'h33;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got %b exp 1", out_valid); end
        n_checks++; if (out_bits !== exp_bits) begin n_fail++; $display("FAIL gap_bits got %h exp %h", out_bits, exp_bits); end
        n_checks++; if (out_k !== map_k(7'd9)) begin n_fail++; $display("FAIL gap_k got %b exp %b", out_k, map_k(7'd9)); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL gap_drain_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h12345678; in_k = 7'd11; tick();
        in_data = 32'h9ABCDEF0; in_k = 7'd11; tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_bits !== '0) begin n_fail++; $display("FAIL midrst_bits got %h exp 0", out_bits); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
        load4(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 7'd0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_valid got %b exp 1", out_valid); end
        n_checks++; if (out_bits !== {N{1'b1}}) begin n_fail++; $display("FAIL midrst_ones got %h exp all ones", out_bits); end
        n_checks++; if (out_k !== '0) begin n_fail++; $display("FAIL midrst_k got %b exp 0", out_k); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [LN-1:0] kv [3];
        logic [0:N-1]  exp_bits;
        int            v;
        int            p;
        kv = '{7'd17, 7'd42, 7'd100};
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            v = c / 5; p = c % 5;
            if (p < 4) begin
                in_data = stream_beat(v, p);
                in_k = (p == 0) ? kv[v] : 7'h7f;
            end else begin
                in_data = 32'h5EED5EED;
                in_k = 7'h01;
            end
            tick();
            n_checks++; if (out_valid !== (p == 3)) begin n_fail++; $display("FAIL stream_valid cycle %0d got %b exp %b", c, out_valid, (p == 3)); end
            n_checks++; if (in_ready !== (p != 3)) begin n_fail++; $display("FAIL stream_ready cycle %0d got %b exp %b", c, in_ready, (p != 3)); end
            if (p == 3) begin
                exp_bits = pack4(stream_beat(v, 0), stream_beat(v, 1), stream_beat(v, 2), stream_beat(v, 3));
                n_checks++; if (out_bits !== exp_bits) begin n_fail++; $display("FAIL stream_bits vec %0d got %h exp %h", v, out_bits, exp_bits); end
                n_checks++; if (out_k !== map_k(kv[v])) begin n_fail++; $display("FAIL stream_k vec %0d got %b exp %b", v, out_k, map_k(kv[v])); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        load4(32'hFFFF0000, 32'h0000FFFF, 32'hF0F0F0F0, 32'h0F0F0F0F, 7'h4d);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstfull_pre_valid got %b exp 1", out_valid); end
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D; in_k = 7'd6;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_valid got %b exp 0", out_valid); end
        n_checks++; if (out_bits !== '0) begin n_fail++; $display("FAIL rstfull_bits got %h exp 0", out_bits); end
        n_checks++; if (out_k !== '0) begin n_fail++; $display("FAIL rstfull_k got %b exp 0", out_k); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_ready got %b exp 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_stay_idle got %b exp 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_k = '0; out_ready = 1'b0;
        test_reset();
        test_basic_load();
        test_backpressure();
        test_gappy();
        test_mid_reset();
        test_streaming();
        test_reset_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got timeout exp completion");
        $fatal(1, "bench did not complete");
    end

endmodule
